// File: rtl/fml_arbiter_if.sv
// rtl/fml_arbiter_if.sv - FML master-side and controller-side bus bundle for fml_arbiter
interface fml_arbiter_if #(
    parameter int N     = 4,
    parameter int ADR_W = 26,
    parameter int DW    = 32
);
    logic [N*ADR_W-1:0]  m_adr;
    logic [N-1:0]        m_stb;
    logic [N-1:0]        m_we;
    logic [N-1:0]        m_eack;
    logic [N*DW/8-1:0]   m_sel;
    logic [N*DW-1:0]     m_di;
    logic [DW-1:0]       m_do;
    logic [ADR_W-1:0]    s_adr;
    logic                s_stb;
    logic                s_we;
    logic                s_eack;
    logic [DW/8-1:0]     s_sel;
    logic [DW-1:0]       s_di;
    logic [DW-1:0]       s_do;

    // Arbiter view: requests from the masters in, controller port out.
    modport slave (
        input  m_adr, m_stb, m_we, m_sel, m_di, s_eack, s_do,
        output m_eack, m_do, s_adr, s_stb, s_we, s_sel, s_di
    );

    // Environment view: masters plus the DDR controller.
    modport master (
        output m_adr, m_stb, m_we, m_sel, m_di, s_eack, s_do,
        input  m_eack, m_do, s_adr, s_stb, s_we, s_sel, s_di
    );
endinterface

// File: rtl/fml_arbiter.sv
// rtl/fml_arbiter.sv - round-robin arbiter sharing one FML port among N masters
module fml_arbiter #(
    parameter int N     = 4,
    parameter int ADR_W = 26,
    parameter int DW    = 32,
    parameter int BURST = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    fml_arbiter_if.slave  bus
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {IDLE, GRANT, WDATA} state_t;

    state_t         state, state_nx;
    logic [GW-1:0]  g, g_nx;
    logic [GW-1:0]  last, last_nx;
    logic [BW-1:0]  beat, beat_nx;
    logic [GW-1:0]  rr_pick;
    logic           rr_any;

    // First requester found scanning upward from the one after the last served master.
    always_comb begin
        rr_pick = '0;
        rr_any  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!rr_any && bus.m_stb[(int'(last) + k) % N]) begin
                rr_any  = 1'b1;
                rr_pick = GW'((int'(last) + k) % N);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            g     <= '0;
            last  <= GW'(N - 1);
            beat  <= '0;
        end else begin
            state <= state_nx;
            g     <= g_nx;
            last  <= last_nx;
            beat  <= beat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        g_nx     = g;
        last_nx  = last;
        beat_nx  = beat;
        case (state)
            IDLE: begin
                if (rr_any) begin
                    g_nx     = rr_pick;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (bus.s_eack) begin
                    last_nx = g;
                    if (bus.m_we[g]) begin
                        beat_nx  = '0;
                        state_nx = WDATA;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (!bus.m_stb[g]) begin
                    // Strobe withdrawn before eack: drop the grant without crediting it.
                    state_nx = IDLE;
                end
            end
            WDATA: begin
                beat_nx = beat + 1'b1;
                if (beat == BW'(BURST - 1)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.s_stb  = 1'b0;
        bus.s_we   = 1'b0;
        bus.s_adr  = '0;
        bus.s_sel  = '0;
        bus.s_di   = '0;
        bus.m_eack = '0;
        case (state)
            GRANT: begin
                bus.s_stb     = bus.m_stb[g];
                bus.s_we      = bus.m_we[g];
                bus.s_adr     = bus.m_adr[g*ADR_W +: ADR_W];
                bus.m_eack[g] = bus.s_eack;
            end
            WDATA: begin
                bus.s_di  = bus.m_di[g*DW +: DW];
                bus.s_sel = bus.m_sel[g*SW +: SW];
            end
            default: ;
        endcase
    end

    // Read data goes to every master; the requester times its own capture.
    assign bus.m_do = bus.s_do;
endmodule

// File: tb/tb_fml_arbiter.sv
// tb/tb_fml_arbiter.sv - scoreboard bench for fml_arbiter with randomized masters and controller
module tb_fml_arbiter;
    localparam int N     = 4;
    localparam int ADR_W = 26;
    localparam int DW    = 32;
    localparam int BURST = 4;
    localparam int SW    = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fml_arbiter_if #(.N(N), .ADR_W(ADR_W), .DW(DW)) bus ();

    fml_arbiter #(.N(N), .ADR_W(ADR_W), .DW(DW), .BURST(BURST)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int              m;
        logic [ADR_W-1:0] adr;
        logic            we;
        logic [DW-1:0]   data;
        logic [SW-1:0]   sel;
    } txn_t;

    txn_t            mt [N][8];
    int              mcnt [N];
    int              midx [N];
    bit              active [N];
    int              wb [N];
    logic [DW-1:0]   wbase [N];
    logic [SW-1:0]   wsel [N];
    txn_t            exp_q [$];
    int              errors = 0;
    int              checks = 0;
    int              model_last = N - 1;
    bit              start_req = 1'b0;
    bit              abort_req = 1'b0;
    int              ctl_dly_fixed = -1;
    int              wr_left = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic present(input int i);
        bus.m_stb[i]                 = 1'b1;
        bus.m_we[i]                  = mt[i][midx[i]].we;
        bus.m_adr[i*ADR_W +: ADR_W]  = mt[i][midx[i]].adr;
    endtask

    // Masters and controller model: drive just after each rising edge.
    initial begin : drv
        logic [N-1:0] ea;
        int cnt;
        int dly;
        cnt = 0;
        dly = 0;
        bus.m_stb = '0; bus.m_we = '0; bus.m_adr = '0; bus.m_di = '0; bus.m_sel = '0;
        bus.s_eack = 1'b0; bus.s_do = '0;
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0; wb[i] = -1; midx[i] = 0; mcnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            ea = bus.m_eack;
            @(posedge clk);
            #1;
            if (abort_req) begin
                for (int i = 0; i < N; i++) begin
                    active[i] = 1'b0; wb[i] = -1; midx[i] = mcnt[i];
                end
                bus.m_stb = '0;
                ea = '0;
                abort_req = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (ea[i] && active[i]) begin
                    if (mt[i][midx[i]].we) begin
                        wb[i] = 0; wbase[i] = mt[i][midx[i]].data; wsel[i] = mt[i][midx[i]].sel;
                    end
                    midx[i]++;
                    if (midx[i] < mcnt[i]) present(i);
                    else begin
                        active[i] = 1'b0;
                        bus.m_stb[i] = 1'b0;
                        bus.m_we[i] = 1'($urandom);
                        bus.m_adr[i*ADR_W +: ADR_W] = ADR_W'($urandom);
                    end
                end else if (wb[i] >= 0) begin
                    wb[i]++;
                end
                if (wb[i] >= BURST) wb[i] = -1;
                if (wb[i] >= 0) begin
                    bus.m_di[i*DW +: DW] = wbase[i] + DW'(wb[i]);
                    bus.m_sel[i*SW +: SW] = wsel[i];
                end else begin
                    bus.m_di[i*DW +: DW] = DW'($urandom);
                    bus.m_sel[i*SW +: SW] = SW'($urandom);
                end
            end
            if (start_req) begin
                for (int i = 0; i < N; i++) begin
                    if (mcnt[i] > 0) begin
                        active[i] = 1'b1; midx[i] = 0; present(i);
                    end
                end
                start_req = 1'b0;
            end
            bus.s_do = DW'($urandom);
            #1;
            if (bus.s_stb) begin
                if (cnt >= dly) begin
                    bus.s_eack = 1'b1;
                    cnt = 0;
                    dly = (ctl_dly_fixed >= 0) ? ctl_dly_fixed : int'($urandom_range(0, 3));
                end else begin
                    bus.s_eack = 1'b0;
                    cnt++;
                end
            end else begin
                bus.s_eack = 1'b0;
                cnt = 0;
                dly = (ctl_dly_fixed >= 0) ? ctl_dly_fixed : int'($urandom_range(0, 3));
            end
        end
    end

    // Monitor: compares the controller-side port against the expected grant queue.
    initial begin : mon
        txn_t cur;
        txn_t f;
        logic [N-1:0] onehot;
        int k;
        k = 0;
        cur = '{m: 0, adr: '0, we: 1'b0, data: '0, sel: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_left = 0;
                continue;
            end
            chk(bus.m_do == bus.s_do, "m_do_bcast", 64'(bus.m_do), 64'(bus.s_do));
            if (wr_left > 0) begin
                chk(bus.s_di == cur.data + DW'(k) && bus.s_sel == cur.sel && !bus.s_stb, "wr_beat",
                    {27'd0, bus.s_stb, bus.s_sel, bus.s_di}, {28'd0, cur.sel, cur.data + DW'(k)});
                k++;
                wr_left--;
            end else begin
                chk(bus.s_di == '0 && bus.s_sel == '0, "idle_data", {28'd0, bus.s_sel, bus.s_di}, 64'd0);
            end
            if (bus.s_stb) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_stb", 64'(bus.s_adr), 64'd0);
                end else begin
                    f = exp_q[0];
                    chk(bus.s_adr == f.adr && bus.s_we == f.we, "grant_adr",
                        64'({bus.s_we, bus.s_adr}), 64'({f.we, f.adr}));
                    if (bus.s_eack) begin
                        onehot = N'(1) << f.m;
                        chk(bus.m_eack == onehot, "eack_route", 64'(bus.m_eack), 64'(onehot));
                        void'(exp_q.pop_front());
                        if (f.we) begin
                            cur = f; k = 0; wr_left = BURST;
                        end
                    end else begin
                        chk(bus.m_eack == '0, "eack_quiet", 64'(bus.m_eack), 64'd0);
                    end
                end
            end else begin
                chk(bus.s_adr == '0 && !bus.s_we && bus.m_eack == '0, "idle_ctrl",
                    64'({bus.m_eack, bus.s_we, bus.s_adr}), 64'd0);
            end
        end
    end

    task automatic gen_txns();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < mcnt[i]; j++) begin
                mt[i][j].m    = i;
                mt[i][j].adr  = ADR_W'($urandom);
                mt[i][j].we   = 1'($urandom_range(0, 1));
                mt[i][j].data = DW'($urandom);
                mt[i][j].sel  = SW'($urandom);
            end
    endtask

    // Every requester stays pending until served, so the service order is a
    // plain rotation over masters with remaining work, starting after the last served.
    task automatic launch();
        int rem [N];
        int total;
        int cur;
        total = 0;
        for (int i = 0; i < N; i++) begin rem[i] = mcnt[i]; total += mcnt[i]; end
        cur = model_last;
        while (total > 0) begin
            for (int k = 1; k <= N; k++) begin
                if (rem[(cur + k) % N] > 0) begin
                    cur = (cur + k) % N;
                    exp_q.push_back(mt[cur][mcnt[cur] - rem[cur]]);
                    rem[cur]--;
                    total--;
                    break;
                end
            end
        end
        model_last = cur;
        start_req = 1'b1;
    endtask

    task automatic wait_done();
        bit busy;
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            t++;
            busy = (exp_q.size() != 0) || (wr_left != 0) || start_req;
            for (int i = 0; i < N; i++) if (active[i]) busy = 1'b1;
            if (!busy) break;
            if (t > 3000) begin
                chk(1'b0, "batch_timeout", 64'(exp_q.size()), 64'd0);
                abort_req = 1'b1;
                exp_q.delete();
                #2 rst_n = 1'b0;
                model_last = N - 1;
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_cnt(input int c0, input int c1, input int c2, input int c3);
        mcnt[0] = c0; mcnt[1] = c1; mcnt[2] = c2; mcnt[3] = c3;
        gen_txns();
    endtask

    initial begin : main
        int t;
        // Reset with all four requesting; master 0 takes two reads so service wraps to it.
        set_cnt(2, 1, 1, 1);
        for (int i = 0; i < N; i++) for (int j = 0; j < mcnt[i]; j++) mt[i][j].we = 1'b0;
        ctl_dly_fixed = 3;
        launch();
        repeat (3) @(negedge clk);
        #1;
        chk(bus.s_stb == 1'b0 && bus.m_eack == '0 && bus.s_adr == '0 && !bus.s_we &&
            bus.s_sel == '0 && bus.s_di == '0, "reset_outputs",
            64'({bus.m_eack, bus.s_stb, bus.s_we}), 64'd0);
        #1 rst_n = 1'b1;
        #1;
        chk(bus.s_stb == 1'b0, "release_idle", 64'(bus.s_stb), 64'd0);
        @(negedge clk);
        chk(bus.s_stb && bus.s_adr == mt[0][0].adr, "first_grant_m0",
            64'({bus.s_stb, bus.s_adr}), 64'({1'b1, mt[0][0].adr}));
        wait_done();
        ctl_dly_fixed = -1;

        set_cnt(0, 0, 1, 0);
        mt[2][0].adr = 26'h0123456;
        mt[2][0].we  = 1'b0;
        launch();
        wait_done();

        set_cnt(0, 1, 0, 0);
        mt[1][0].we = 1'b1; mt[1][0].data = 32'hA0; mt[1][0].sel = 4'hF;
        launch();
        wait_done();

        ctl_dly_fixed = 20;
        set_cnt(1, 0, 0, 1);
        launch();
        wait_done();
        ctl_dly_fixed = -1;

        // Reset in the third write beat; afterwards master 0 must win over master 3.
        set_cnt(0, 1, 0, 0);
        mt[1][0].we = 1'b1;
        launch();
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.m_eack[1] && t < 200);
        chk(bus.m_eack[1] == 1'b1, "mid_write_eack", 64'(bus.m_eack), 64'd2);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(bus.s_stb == 1'b0 && bus.m_eack == '0 && bus.s_adr == '0 && !bus.s_we &&
            bus.s_sel == '0 && bus.s_di == '0, "reset_mid_write",
            {28'd0, bus.s_sel, bus.s_di}, 64'd0);
        abort_req = 1'b1;
        exp_q.delete();
        model_last = N - 1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        set_cnt(1, 0, 0, 1);
        mt[0][0].we = 1'b0; mt[3][0].we = 1'b0;
        launch();
        wait_done();

        for (int b = 0; b < 25; b++) begin
            set_cnt($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            launch();
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
